// File: rtl/char_plane_pkg.sv
`default_nettype none
// ============================================================================
// Module   : char_plane_pkg
// Purpose  : Shared definitions for the text-console character plane:
//            default screen geometry, blank character ID and the controller
//            state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package char_plane_pkg;

  localparam int DEF_ROWS   = 15;
  localparam int DEF_COLS   = 40;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ROW_W  = 4;
  localparam int DEF_COL_W  = 6;
  localparam int DEF_BLANK  = 0;

  // Controller states; busy is simply "not idle".
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CLEAR_LINE = 2'd1,
    ST_CLEAR_ALL  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/char_plane_ram.sv
`default_nettype none
// ============================================================================
// Module   : char_plane_ram
// Purpose  : Simple dual-port character store. One synchronous write port and
//            one synchronous registered read port; array has no reset so it
//            maps onto block RAM. Read of a cell written on the same edge
//            returns the old contents.
// Ports    : clk      - clock
//            i_we     - write enable
//            i_waddr  - write address
//            i_wdata  - write data
//            i_raddr  - read address
//            o_rdata  - registered read data (1-cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
module char_plane_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 600
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
    rdata_q <= mem[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/char_plane_scroll.sv
`default_nettype none
// ============================================================================
// Module   : char_plane_scroll
// Purpose  : ROWS x COLS character-cell plane for the text console. Scrolling
//            rotates a top-row pointer and blank-fills the new bottom line one
//            cell per cycle; a full clear sweeps every cell. Writes are taken
//            only while idle; reads are always served with 1-cycle latency.
// Ports    : clock, reset_n          - clock, async active-low reset
//            wr_en/wr_row/wr_col/wr_data - logical-cell write port
//            rd_row/rd_col/rd_data   - logical-cell read port (registered)
//            scroll_req, clear_req   - single-cycle command pulses
//            busy                    - a clear sweep (line or full) is running
//            top_row                 - physical row holding logical row 0
// Revision : 1.0 - initial release
// ============================================================================
module char_plane_scroll
  import char_plane_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROW_W  = DEF_ROW_W,
  parameter int COL_W  = DEF_COL_W,
  parameter int BLANK  = DEF_BLANK
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [COL_W-1:0]  rd_col,
  output logic [DATA_W-1:0] rd_data,
  input  logic              scroll_req,
  input  logic              clear_req,
  output logic              busy,
  output logic [ROW_W-1:0]  top_row
);

  localparam int                ADDR_W     = $clog2(ROWS * COLS);
  localparam logic [ADDR_W-1:0] SWEEP_LAST = ADDR_W'(ROWS * COLS - 1);
  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [DATA_W-1:0] BLANK_V    = DATA_W'(BLANK);

  // Logical (row, col) -> linear address through the rotating top pointer.
  // The add is one bit wider so row + top cannot overflow before the wrap.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col,
                                                 input logic [ROW_W-1:0] top);
    logic [ROW_W:0] phys;
    phys = {1'b0, row} + {1'b0, top};
    if (int'(phys) >= ROWS) begin
      phys = phys - (ROW_W+1)'(ROWS);
    end
    return ADDR_W'(phys) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  top_q, top_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  tgt_q, tgt_d;
  logic              rd_blank_q, rd_blank_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  logic              wr_in_range;
  logic              rd_in_range;
  logic [ROW_W-1:0]  top_inc;

  assign wr_in_range = (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
  assign rd_in_range = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);
  assign top_inc     = (top_q == ROW_LAST) ? '0 : top_q + 1'b1;

  // --------------------------------------------------------------------------
  // Controller next-state and RAM write-port mux
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    top_d     = top_q;
    pend_d    = pend_q;
    sweep_d   = sweep_q;
    col_d     = col_q;
    tgt_d     = tgt_q;
    ram_we    = 1'b0;
    ram_waddr = map_addr(wr_row, wr_col, top_q);
    ram_wdata = wr_data;

    case (state_q)
      ST_IDLE: begin
        // Same-cycle write uses the pre-scroll mapping (top_q).
        ram_we = wr_en && wr_in_range && !clear_req;
        if (scroll_req) begin
          top_d   = top_inc;
          tgt_d   = top_q;       // old top line becomes the new bottom line
          col_d   = '0;
          state_d = ST_CLEAR_LINE;
        end
      end

      ST_CLEAR_LINE: begin
        ram_we    = 1'b1;
        ram_waddr = ADDR_W'(tgt_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
        ram_wdata = BLANK_V;
        if (scroll_req) begin
          pend_d = 1'b1;         // single-entry queue; extras fold into it
        end
        if (col_q == COL_LAST) begin
          // A request arriving on the last column still counts as pending.
          if (pend_q || scroll_req) begin
            top_d  = top_inc;
            tgt_d  = top_q;
            col_d  = '0;
            pend_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end

      ST_CLEAR_ALL: begin
        ram_we    = 1'b1;
        ram_waddr = sweep_q;
        ram_wdata = BLANK_V;
        if (sweep_q == SWEEP_LAST) begin
          sweep_d = '0;
          state_d = ST_IDLE;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_CLEAR_ALL;
        sweep_d = '0;
      end
    endcase

    // Full clear overrides any state and any same-cycle scroll.
    if (clear_req) begin
      state_d = ST_CLEAR_ALL;
      sweep_d = '0;
      top_d   = '0;
      pend_d  = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Read path: address mapping plus a registered mask flag aligned with the
  // RAM's registered output.
  // --------------------------------------------------------------------------
  always_comb begin
    ram_raddr  = rd_in_range ? map_addr(rd_row, rd_col, top_q) : '0;
    rd_blank_d = !rd_in_range
              || (state_q == ST_CLEAR_ALL)
              || ((state_q == ST_CLEAR_LINE) && (rd_row == ROW_LAST));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_CLEAR_ALL;
      top_q      <= '0;
      pend_q     <= 1'b0;
      sweep_q    <= '0;
      col_q      <= '0;
      tgt_q      <= '0;
      rd_blank_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      top_q      <= top_d;
      pend_q     <= pend_d;
      sweep_q    <= sweep_d;
      col_q      <= col_d;
      tgt_q      <= tgt_d;
      rd_blank_q <= rd_blank_d;
    end
  end

  char_plane_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (ROWS * COLS)
  ) u_ram (
    .clk     (clock),
    .i_we    (ram_we),
    .i_waddr (ram_waddr),
    .i_wdata (ram_wdata),
    .i_raddr (ram_raddr),
    .o_rdata (ram_rdata)
  );

  assign rd_data = rd_blank_q ? BLANK_V : ram_rdata;
  assign busy    = (state_q != ST_IDLE);
  assign top_row = top_q;

endmodule
`default_nettype wire

// File: tb/tb_char_plane_scroll.sv
`default_nettype none
// ============================================================================
// Module   : tb_char_plane_scroll
// Purpose  : Self-checking bench for char_plane_scroll. A logical screen image
//            (rows shifted up on scroll, blanked on clear) is the reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_char_plane_scroll;

  localparam int ROWS   = 15;
  localparam int COLS   = 40;
  localparam int DATA_W = 8;
  localparam int ROW_W  = 4;
  localparam int COL_W  = 6;
  localparam int LIMIT  = 2000;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              wr_en;
  logic [ROW_W-1:0]  wr_row;
  logic [COL_W-1:0]  wr_col;
  logic [DATA_W-1:0] wr_data;
  logic [ROW_W-1:0]  rd_row;
  logic [COL_W-1:0]  rd_col;
  logic [DATA_W-1:0] rd_data;
  logic              scroll_req;
  logic              clear_req;
  logic              busy;
  logic [ROW_W-1:0]  top_row;

  int checks   = 0;
  int failures = 0;

  // Reference: logical screen contents and expected top pointer.
  logic [DATA_W-1:0] scr [ROWS][COLS];
  int                m_top;

  char_plane_scroll #(
    .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W),
    .ROW_W(ROW_W), .COL_W(COL_W), .BLANK(0)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .scroll_req(scroll_req), .clear_req(clear_req),
    .busy(busy), .top_row(top_row)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        scr[r][c] = '0;
    m_top = 0;
  endfunction

  function automatic void m_scroll();
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++)
        scr[r][c] = scr[r+1][c];
    for (int c = 0; c < COLS; c++)
      scr[ROWS-1][c] = '0;
    m_top = (m_top + 1) % ROWS;
  endfunction

  function automatic int m_read(input int r, input int c);
    if (r >= ROWS || c >= COLS) return 0;
    return int'(scr[r][c]);
  endfunction

  // Write while idle; model follows only for in-range cells.
  task automatic do_write(input int r, input int c, input int d);
    wr_en = 1'b1; wr_row = ROW_W'(r); wr_col = COL_W'(c); wr_data = DATA_W'(d);
    step();
    wr_en = 1'b0;
    if (r < ROWS && c < COLS) scr[r][c] = DATA_W'(d);
  endtask

  task automatic do_read(input string tag, input int r, input int c);
    rd_row = ROW_W'(r); rd_col = COL_W'(c);
    step();
    chk(tag, int'(rd_data), m_read(r, c));
  endtask

  task automatic check_screen(input string tag);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        do_read(tag, r, c);
    chk({tag, "_top"}, int'(top_row), m_top);
  endtask

  // Count cycles until busy drops, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < LIMIT) begin
      step();
      n++;
    end
  endtask

  // Scroll while idle; during the line clear, probe the bottom row (must read
  // blank) and attempt writes (must be dropped).
  task automatic scroll_probed(input string tag);
    int n;
    scroll_req = 1'b1;
    step();
    scroll_req = 1'b0;
    m_scroll();
    n = 0;
    while (busy && n < LIMIT) begin
      rd_row  = ROW_W'(ROWS - 1);
      rd_col  = COL_W'($urandom_range(COLS - 1));
      wr_en   = 1'b1;
      wr_row  = ROW_W'($urandom_range(ROWS - 1));
      wr_col  = COL_W'($urandom_range(COLS - 1));
      wr_data = DATA_W'($urandom_range(255, 1));
      step();
      n++;
      chk({tag, "_bottom_masked"}, int'(rd_data), 0);
    end
    wr_en = 1'b0;
    chk({tag, "_busy_cycles"}, n, COLS);
    chk({tag, "_top"}, int'(top_row), m_top);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    rd_row = '0; rd_col = '0; scroll_req = 1'b0; clear_req = 1'b0;
    m_clear();

    // Reset state
    repeat (3) step();
    chk("reset_rd_data", int'(rd_data), 0);
    chk("reset_top_row", int'(top_row), 0);
    chk("reset_busy", int'(busy), 1);

    // Release: full sweep of ROWS*COLS cycles
    reset_n = 1'b1;
    wait_idle(n);
    chk("init_sweep_cycles", n, ROWS * COLS);
    check_screen("init_blank");

    // Read-before-write, then the new value
    wr_en = 1'b1; wr_row = '0; wr_col = '0; wr_data = 8'h41;
    rd_row = '0; rd_col = '0;
    step();
    wr_en = 1'b0;
    chk("rbw_old_data", int'(rd_data), 0);
    scr[0][0] = 8'h41;
    do_read("read_0_0", 0, 0);

    // Out-of-range writes and reads
    do_write(15, 0, 8'hFF);
    do_write(0, 40, 8'hFF);
    do_write(15, 63, 8'hFF);
    do_read("oor_read_row", 15, 0);
    do_read("oor_read_col", 0, 40);
    check_screen("after_oor");

    // Random fill
    for (int i = 0; i < 200; i++)
      do_write($urandom_range(ROWS - 1), $urandom_range(COLS - 1), $urandom_range(255));
    check_screen("random_fill");

    // Single scroll moves (1,5) to (0,5)
    do_write(1, 5, 8'h42);
    scroll_probed("scroll1");
    do_read("scrolled_0_5", 0, 5);
    check_screen("after_scroll1");

    // Write in the same cycle as a scroll uses the pre-scroll mapping
    wr_en = 1'b1; wr_row = 4'd2; wr_col = 6'd7; wr_data = 8'h5A;
    scroll_req = 1'b1;
    step();
    wr_en = 1'b0; scroll_req = 1'b0;
    scr[2][7] = 8'h5A;
    m_scroll();
    wait_idle(n);
    chk("wr_scroll_busy", n, COLS);
    do_read("wr_scroll_moved", 1, 7);

    // Consecutive scrolls past the wrap point, refilling a line each time
    for (int k = 0; k < ROWS; k++) begin
      for (int c = 0; c < COLS; c += 3)
        do_write($urandom_range(ROWS - 2), c, $urandom_range(255, 1));
      scroll_probed("wrap_scroll");
    end
    check_screen("after_wrap");

    // Two extra requests in one line clear: only one is kept
    scroll_req = 1'b1;
    step();
    m_scroll();
    n = 0;
    while (busy && n < LIMIT) begin
      scroll_req = (n == 5 || n == 12);
      step();
      n++;
    end
    scroll_req = 1'b0;
    m_scroll();
    chk("double_scroll_busy", n, 2 * COLS);
    check_screen("after_double");

    // Clear during a line clear with a pending scroll
    scroll_req = 1'b1;
    step();
    m_scroll();
    n = 0;
    while (busy && n < 20) begin
      scroll_req = (n == 10);
      step();
      n++;
    end
    scroll_req = 1'b0;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    m_clear();
    chk("clear_top_row", int'(top_row), 0);
    wait_idle(n);
    chk("clear_sweep_cycles", n, ROWS * COLS);
    check_screen("after_clear");

    // Normal operation after the clear
    for (int i = 0; i < 20; i++)
      do_write($urandom_range(ROWS - 1), $urandom_range(COLS - 1), $urandom_range(255));
    check_screen("post_clear_fill");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
